mips_pipe_stage: RTL and testbench
==================================

# mips_pipe_stage

Parametrised pipeline stage register for the MIPS core, generalising the fixed-width inter-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB) into one block. It adds a valid/ready handshake, an optional skid entry for a registered back-pressure path, synchronous flush with bubble injection, and a saturating stall counter. One instance sits between each pair of pipeline stages, with CTRL_W and DATA_W set per boundary.

## Interface
- CTRL_W, 20: width of the control word; forced to BUBBLE_CTRL when the stage holds no valid entry.
- DATA_W, 175: payload width. Default is ID/EX: PC, rd1, rd2, sign-ext and shift (5×32) plus RS, RT and RD (3×5).
- BUBBLE_CTRL, 0: control value presented on bubbles.
- SKID, 1: 1 gives a two-entry stage with registered O_READY; 0 gives a single entry with combinational ready.
- CNT_W, 16: stall counter width.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RESET  in  1  reset; synchronous, active-high.
- I_FLUSH  in  1  synchronous flush; discards all held entries.
- I_VALID  in  1  upstream entry valid.
- O_READY  out  1  stage can accept an entry this cycle.
- I_CTRL  in  CTRL_W  upstream control word.
- I_DATA  in  DATA_W  upstream payload.
- O_VALID  out  1  head entry valid.
- I_READY  in  1  downstream accepts the head entry.
- O_CTRL  out  CTRL_W  head control word; BUBBLE_CTRL when O_VALID=0.
- O_DATA  out  DATA_W  head payload.
- O_STALL_CNT  out  CNT_W  saturating count of stalled cycles.

## Operation
**Handshakes**
- Accept: I_VALID && O_READY.
- Issue: O_VALID && I_READY.
- Entries leave in arrival order.

**SKID=1.** Main register drives the outputs; the skid register holds one extra entry. O_READY = !skid_full, taken from a flop. State transitions:
- EMPTY: accept → ONE.
- ONE: accept without issue → TWO (input goes to skid). Accept with issue → ONE (main reloads from input). Issue only → EMPTY.
- TWO: issue → ONE (skid moves to main). No accept is possible because O_READY=0.

**SKID=0.** One register. O_READY = !O_VALID || I_READY, combinational. EMPTY↔ONE only.

**Flush and reset priority**
- I_FLUSH: next cycle is EMPTY, O_VALID=0, O_CTRL=BUBBLE_CTRL, O_DATA=0.
- An accept that coincides with a flush is dropped.
- RESET takes priority over I_FLUSH.

**Stall counter**
- O_STALL_CNT increments on every cycle with O_VALID && !I_READY.
- It saturates at 2^CNT_W−1.
- It is cleared only by RESET; flush does not clear it.

**Output values**
- O_CTRL = main valid ? main_ctrl : BUBBLE_CTRL.
- O_DATA holds its last value while O_VALID=0, except after RESET or flush, where it is 0.

## Timing
- Reset values (cycle after RESET is sampled high): O_VALID=0, O_CTRL=BUBBLE_CTRL, O_DATA=0, O_STALL_CNT=0, O_READY=1. Skid is empty.
- Latency: an entry accepted at edge n is on the outputs after edge n, with O_VALID=1 in cycle n+1.
- Throughput: one entry per cycle while I_READY=1.
- SKID=1 back-pressure: O_READY falls one cycle after I_READY falls, only if an entry arrives in that cycle.
- No combinational path from I_READY to O_READY when SKID=1.
- Reset or flush mid-transfer: all held entries are discarded within one edge. An entry issued in the same cycle as the flush counts as delivered to downstream.

## Structure
- Package mips_pipe_pkg holds the following, so all stage instances agree:
  - state enum {EMPTY, ONE, TWO};
  - default widths: ID/EX payload 175, control 20;
  - field offset constants for slicing the ID/EX payload (PC, RD1, RD2, SEXT, SHIFT, RS, RT, RD).
- One sub-module: mips_sat_counter (CNT_W, synchronous clear, increment enable). It is reused for the other pipeline performance counters.

## Test plan
1. Reset: RESET=1 for 2 cycles with I_VALID=1 → O_VALID=0, O_CTRL=0, O_DATA=0, O_READY=1, O_STALL_CNT=0.
2. Streaming: I_READY=1, send entries with ctrl 0x00001..0x00005 on consecutive cycles → same values appear on O_CTRL one cycle later each, no gaps.
3. Skid fill (SKID=1): entries A, B; I_READY drops the cycle A appears → O_READY=0 next cycle; release I_READY → A then B issued in order; O_STALL_CNT equals the number of stalled cycles (e.g. 3 after 3 stalled cycles).
4. Flush in state TWO, with I_VALID=1 in the same cycle → next cycle O_VALID=0, O_CTRL=BUBBLE_CTRL, O_DATA=0; the incoming entry is absent afterwards.
5. Saturation: CNT_W=4, hold I_READY=0 with a valid entry for 20 cycles → O_STALL_CNT stops at 15; flush leaves it at 15; RESET clears it to 0.
6. SKID=0: O_VALID=1, I_READY=1, I_VALID=1 → O_READY=1 in the same cycle and the new entry replaces the old; with I_READY=0, O_READY=0.

Source files
------------

// File: rtl/mips_pipe_pkg.sv
// Shared types and constants for the MIPS pipeline stage registers, so every
// inter-stage instance agrees on state encoding and the ID/EX payload layout.
package mips_pipe_pkg;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } stage_state_e;

   localparam int ID_EX_CTRL_W = 20;
   localparam int ID_EX_DATA_W = 175;
   localparam int WORD_W       = 32;
   localparam int REG_W        = 5;

   // ID/EX payload layout, LSB first: RD, RT, RS, SHIFT, SEXT, RD2, RD1, PC
   localparam int OFF_RD    = 0;
   localparam int OFF_RT    = OFF_RD    + REG_W;
   localparam int OFF_RS    = OFF_RT    + REG_W;
   localparam int OFF_SHIFT = OFF_RS    + REG_W;
   localparam int OFF_SEXT  = OFF_SHIFT + WORD_W;
   localparam int OFF_RD2   = OFF_SEXT  + WORD_W;
   localparam int OFF_RD1   = OFF_RD2   + WORD_W;
   localparam int OFF_PC    = OFF_RD1   + WORD_W;

endpackage

// File: rtl/mips_pipe_stage_if.sv
// Valid/ready handshake bundle between two MIPS pipeline stages; the stage
// register itself takes the slave view, its neighbours the master view.
interface mips_pipe_stage_if
   import mips_pipe_pkg::*;
#(
   parameter int CTRL_W = ID_EX_CTRL_W,
   parameter int DATA_W = ID_EX_DATA_W
) ();

   logic              I_VALID;
   logic              O_READY;
   logic [CTRL_W-1:0] I_CTRL;
   logic [DATA_W-1:0] I_DATA;
   logic              O_VALID;
   logic              I_READY;
   logic [CTRL_W-1:0] O_CTRL;
   logic [DATA_W-1:0] O_DATA;

   modport master (
      output I_VALID, I_CTRL, I_DATA, I_READY,
      input  O_READY, O_VALID, O_CTRL, O_DATA
   );

   modport slave (
      input  I_VALID, I_CTRL, I_DATA, I_READY,
      output O_READY, O_VALID, O_CTRL, O_DATA
   );

endinterface

// File: rtl/mips_sat_counter.sv
// Saturating up-counter with synchronous clear; shared by the pipeline
// performance counters.
module mips_sat_counter #(
   parameter int CNT_W = 16
) (
   input  logic             i_clk,
   input  logic             i_clr,
   input  logic             i_inc,
   output logic [CNT_W-1:0] o_cnt
);

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic [CNT_W-1:0] r_cnt;

   always_ff @(posedge i_clk) begin
      if (i_clr) begin
         r_cnt <= '0;
      end else if (i_inc && (r_cnt != CNT_MAX)) begin
         r_cnt <= r_cnt + CNT_W'(1'b1);
      end else begin
         r_cnt <= r_cnt;
      end
   end

   assign o_cnt = r_cnt;

endmodule

// File: rtl/mips_pipe_stage.sv
// Generic MIPS inter-stage register: valid/ready handshake, optional skid
// entry for a registered ready, flush with bubble injection, stall counter.
module mips_pipe_stage
   import mips_pipe_pkg::*;
#(
   parameter int                CTRL_W      = ID_EX_CTRL_W,
   parameter int                DATA_W      = ID_EX_DATA_W,
   parameter logic [CTRL_W-1:0] BUBBLE_CTRL = '0,
   parameter bit                SKID        = 1'b1,
   parameter int                CNT_W       = 16
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             I_FLUSH,
   mips_pipe_stage_if.slave bus,
   output logic [CNT_W-1:0] O_STALL_CNT
);

   stage_state_e      r_state;
   stage_state_e      w_state_nxt;
   logic [CTRL_W-1:0] r_main_ctrl;
   logic [CTRL_W-1:0] w_main_ctrl_nxt;
   logic [DATA_W-1:0] r_main_data;
   logic [DATA_W-1:0] w_main_data_nxt;
   logic [CTRL_W-1:0] r_skid_ctrl;
   logic [CTRL_W-1:0] w_skid_ctrl_nxt;
   logic [DATA_W-1:0] r_skid_data;
   logic [DATA_W-1:0] w_skid_data_nxt;
   logic              r_valid;
   logic              r_ready;
   logic              w_ready;
   logic              w_accept;
   logic              w_issue;

   // With a skid entry, ready comes straight from a flop so I_READY never reaches O_READY.
   assign w_ready  = SKID ? r_ready : (!r_valid || bus.I_READY);
   assign w_accept = bus.I_VALID && w_ready;
   assign w_issue  = r_valid && bus.I_READY;

   assign bus.O_READY = w_ready;
   assign bus.O_VALID = r_valid;
   assign bus.O_CTRL  = r_main_ctrl;
   assign bus.O_DATA  = r_main_data;

   always_comb begin
      w_state_nxt     = r_state;
      w_main_ctrl_nxt = r_main_ctrl;
      w_main_data_nxt = r_main_data;
      w_skid_ctrl_nxt = r_skid_ctrl;
      w_skid_data_nxt = r_skid_data;
      case (r_state)
         EMPTY: begin
            if (w_accept) begin
               w_state_nxt     = ONE;
               w_main_ctrl_nxt = bus.I_CTRL;
               w_main_data_nxt = bus.I_DATA;
            end else begin
               w_state_nxt = EMPTY;
            end
         end
         ONE: begin
            if (w_accept && !w_issue) begin
               w_state_nxt     = TWO;
               w_skid_ctrl_nxt = bus.I_CTRL;
               w_skid_data_nxt = bus.I_DATA;
            end else if (w_accept) begin
               w_main_ctrl_nxt = bus.I_CTRL;
               w_main_data_nxt = bus.I_DATA;
            end else if (w_issue) begin
               // Going empty: ctrl turns into a bubble, payload keeps its last value
               w_state_nxt     = EMPTY;
               w_main_ctrl_nxt = BUBBLE_CTRL;
            end else begin
               w_state_nxt = ONE;
            end
         end
         TWO: begin
            if (w_issue) begin
               w_state_nxt     = ONE;
               w_main_ctrl_nxt = r_skid_ctrl;
               w_main_data_nxt = r_skid_data;
            end else begin
               w_state_nxt = TWO;
            end
         end
         default: begin
            w_state_nxt     = EMPTY;
            w_main_ctrl_nxt = BUBBLE_CTRL;
            w_main_data_nxt = '0;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RESET || I_FLUSH) begin
         r_state     <= EMPTY;
         r_valid     <= 1'b0;
         r_ready     <= 1'b1;
         r_main_ctrl <= BUBBLE_CTRL;
         r_main_data <= '0;
         r_skid_ctrl <= '0;
         r_skid_data <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_valid     <= (w_state_nxt != EMPTY);
         r_ready     <= (w_state_nxt != TWO);
         r_main_ctrl <= w_main_ctrl_nxt;
         r_main_data <= w_main_data_nxt;
         r_skid_ctrl <= w_skid_ctrl_nxt;
         r_skid_data <= w_skid_data_nxt;
      end
   end

   mips_sat_counter #(
      .CNT_W (CNT_W)
   ) u_stall_cnt (
      .i_clk (CLK),
      .i_clr (RESET),
      .i_inc (r_valid && !bus.I_READY),
      .o_cnt (O_STALL_CNT)
   );

endmodule

// File: tb/tb_mips_pipe_stage.sv
// Bench for mips_pipe_stage: ID/EX default, a 4-bit-counter instance with a
// non-zero bubble, and a SKID=0 instance, each tracked by a queue model.
module tb_mips_pipe_stage;
   import mips_pipe_pkg::*;

   typedef struct packed {
      logic [19:0]  ctrl;
      logic [174:0] data;
   } ent_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rs [3];
   logic         fl [3];
   logic         iv [3];
   logic         ir [3];
   logic [19:0]  ic [3];
   logic [174:0] id [3];

   ent_t         sb_q [3][$];
   logic         m_rdy [3];
   logic [174:0] m_hold [3];
   logic [15:0]  m_cnt [3];
   logic [19:0]  cmask [3];
   logic [174:0] dmask [3];
   logic [19:0]  bub [3];
   logic [15:0]  cmax [3];
   bit           skid_p [3];

   int n_chk = 0;
   int n_err = 0;
   bit sb_on = 1'b0;

   logic [15:0] cnt_a;
   logic [3:0]  cnt_b;
   logic [7:0]  cnt_c;

   mips_pipe_stage_if #(.CTRL_W(20), .DATA_W(175)) ifa ();
   mips_pipe_stage_if #(.CTRL_W(8),  .DATA_W(16))  ifb ();
   mips_pipe_stage_if #(.CTRL_W(8),  .DATA_W(16))  ifc ();

   assign ifa.I_VALID = iv[0];
   assign ifa.I_READY = ir[0];
   assign ifa.I_CTRL  = ic[0];
   assign ifa.I_DATA  = id[0];
   assign ifb.I_VALID = iv[1];
   assign ifb.I_READY = ir[1];
   assign ifb.I_CTRL  = ic[1][7:0];
   assign ifb.I_DATA  = id[1][15:0];
   assign ifc.I_VALID = iv[2];
   assign ifc.I_READY = ir[2];
   assign ifc.I_CTRL  = ic[2][7:0];
   assign ifc.I_DATA  = id[2][15:0];

   mips_pipe_stage u_dut_a (
      .CLK (clk), .RESET (rs[0]), .I_FLUSH (fl[0]), .bus (ifa.slave), .O_STALL_CNT (cnt_a)
   );

   mips_pipe_stage #(
      .CTRL_W (8), .DATA_W (16), .BUBBLE_CTRL (8'hA5), .SKID (1'b1), .CNT_W (4)
   ) u_dut_b (
      .CLK (clk), .RESET (rs[1]), .I_FLUSH (fl[1]), .bus (ifb.slave), .O_STALL_CNT (cnt_b)
   );

   mips_pipe_stage #(
      .CTRL_W (8), .DATA_W (16), .BUBBLE_CTRL (8'h00), .SKID (1'b0), .CNT_W (8)
   ) u_dut_c (
      .CLK (clk), .RESET (rs[2]), .I_FLUSH (fl[2]), .bus (ifc.slave), .O_STALL_CNT (cnt_c)
   );

   task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [174:0] make_data(input int k);
      logic [174:0] d;
      logic [31:0]  w;
      w = 32'(k);
      d = '0;
      d[OFF_PC +: 32]    = 32'h0040_0000 + (w << 2);
      d[OFF_RD1 +: 32]   = w ^ 32'hDEAD_0000;
      d[OFF_RD2 +: 32]   = ~w;
      d[OFF_SEXT +: 32]  = {16'hFFFF, w[15:0]};
      d[OFF_SHIFT +: 32] = w << 5;
      d[OFF_RS +: 5]     = w[4:0];
      d[OFF_RT +: 5]     = w[4:0] + 5'd1;
      d[OFF_RD +: 5]     = w[4:0] + 5'd2;
      return d;
   endfunction

   task automatic model_reset(input int d);
      sb_q[d].delete();
      m_rdy[d]  = 1'b1;
      m_hold[d] = '0;
      m_cnt[d]  = 16'd0;
   endtask

   // Compare one DUT against its model for the current cycle, then advance the model.
   task automatic model_cycle(input int d, input logic ov, input logic [19:0] oc,
                              input logic [174:0] od, input logic ordy, input logic [15:0] ocnt);
      bit   has;
      logic exp_rdy;
      bit   acc;
      bit   iss;
      ent_t e;
      has     = (sb_q[d].size() != 0);
      exp_rdy = skid_p[d] ? m_rdy[d] : (!has || ir[d]);
      chk($sformatf("d%0d_valid", d), 192'(ov), 192'(has));
      chk($sformatf("d%0d_ctrl", d), 192'(oc), has ? 192'(sb_q[d][0].ctrl) : 192'(bub[d]));
      chk($sformatf("d%0d_data", d), 192'(od), has ? 192'(sb_q[d][0].data) : 192'(m_hold[d]));
      chk($sformatf("d%0d_ready", d), 192'(ordy), 192'(exp_rdy));
      chk($sformatf("d%0d_stall", d), 192'(ocnt), 192'(m_cnt[d]));
      iss = has && (ir[d] == 1'b1);
      acc = (iv[d] == 1'b1) && (exp_rdy == 1'b1);
      if (rs[d] == 1'b1) begin
         model_reset(d);
      end else begin
         if (has && (ir[d] == 1'b0) && (m_cnt[d] != cmax[d])) m_cnt[d] = m_cnt[d] + 16'd1;
         if (iss) begin
            m_hold[d] = sb_q[d][0].data;
            void'(sb_q[d].pop_front());
         end
         if (fl[d] == 1'b1) begin
            sb_q[d].delete();
            m_hold[d] = '0;
         end else if (acc) begin
            e.ctrl = ic[d] & cmask[d];
            e.data = id[d] & dmask[d];
            sb_q[d].push_back(e);
         end
         m_rdy[d] = (sb_q[d].size() < 2);
      end
   endtask

   task automatic tick();
      #1;
      if (sb_on) begin
         model_cycle(0, ifa.O_VALID, ifa.O_CTRL, ifa.O_DATA, ifa.O_READY, cnt_a);
         model_cycle(1, ifb.O_VALID, {12'h000, ifb.O_CTRL}, {159'd0, ifb.O_DATA}, ifb.O_READY,
                     {12'h000, cnt_b});
         model_cycle(2, ifc.O_VALID, {12'h000, ifc.O_CTRL}, {159'd0, ifc.O_DATA}, ifc.O_READY,
                     {8'h00, cnt_c});
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle_all();
      for (int d = 0; d < 3; d++) begin
         rs[d] = 1'b0;
         fl[d] = 1'b0;
         iv[d] = 1'b0;
         ir[d] = 1'b1;
      end
   endtask

   initial begin
      for (int d = 0; d < 3; d++) begin
         rs[d] = 1'b1;
         fl[d] = 1'b0;
         iv[d] = 1'b1;
         ir[d] = 1'b1;
         ic[d] = 20'h12345;
         id[d] = make_data(99);
      end
      cmask[0] = 20'hFFFFF; dmask[0] = {175{1'b1}};         bub[0] = 20'h00000; cmax[0] = 16'hFFFF; skid_p[0] = 1'b1;
      cmask[1] = 20'h000FF; dmask[1] = {159'd0, 16'hFFFF};  bub[1] = 20'h000A5; cmax[1] = 16'h000F; skid_p[1] = 1'b1;
      cmask[2] = 20'h000FF; dmask[2] = {159'd0, 16'hFFFF};  bub[2] = 20'h00000; cmax[2] = 16'h00FF; skid_p[2] = 1'b0;

      // Reset held two cycles with I_VALID high
      tick();
      for (int d = 0; d < 3; d++) model_reset(d);
      sb_on = 1'b1;
      tick();
      idle_all();
      tick();

      // Streaming on the ID/EX instance
      for (int k = 1; k <= 5; k++) begin
         iv[0] = 1'b1; ic[0] = 20'(k); id[0] = make_data(k);
         tick();
      end
      iv[0] = 1'b0;
      tick(); tick();

      // Skid fill: A then B with downstream stalled for three cycles
      iv[0] = 1'b1; ic[0] = 20'h0000A; id[0] = make_data(10);
      tick();
      ic[0] = 20'h0000B; id[0] = make_data(11); ir[0] = 1'b0;
      tick();
      iv[0] = 1'b0;
      tick(); tick();
      chk("a_stall_after_3", 192'(cnt_a), 192'(16'd3));
      chk("a_ready_full", 192'(ifa.O_READY), 192'(1'b0));
      ir[0] = 1'b1;
      tick(); tick(); tick();

      // Flush in TWO with an incoming entry, then flush in ONE where the accept would succeed
      iv[0] = 1'b1; ir[0] = 1'b0; ic[0] = 20'h000C1; id[0] = make_data(21);
      tick();
      ic[0] = 20'h000D2; id[0] = make_data(22);
      tick();
      ic[0] = 20'h000E3; id[0] = make_data(23); fl[0] = 1'b1;
      tick();
      fl[0] = 1'b0; iv[0] = 1'b0; ir[0] = 1'b1;
      chk("a_flush_data", 192'(ifa.O_DATA), 192'(175'd0));
      tick(); tick();
      iv[0] = 1'b1; ic[0] = 20'h000F4; id[0] = make_data(24);
      tick();
      ic[0] = 20'h00105; id[0] = make_data(25); fl[0] = 1'b1; ir[0] = 1'b0;
      tick();
      fl[0] = 1'b0; iv[0] = 1'b0; ir[0] = 1'b1;
      tick(); tick();

      // Saturation on the 4-bit counter; flush keeps it, reset clears it
      iv[1] = 1'b1; ic[1] = 20'h0003C; id[1] = {159'd0, 16'hBEEF};
      tick();
      iv[1] = 1'b0; ir[1] = 1'b0;
      repeat (20) tick();
      chk("b_sat", 192'(cnt_b), 192'(4'd15));
      fl[1] = 1'b1;
      tick();
      fl[1] = 1'b0;
      tick();
      chk("b_sat_after_flush", 192'(cnt_b), 192'(4'd15));
      // Flush while in TWO with the head issuing: head is delivered, skid dropped
      iv[1] = 1'b1; ic[1] = 20'h00071; id[1] = {159'd0, 16'h7171};
      tick();
      ic[1] = 20'h00072; id[1] = {159'd0, 16'h7272};
      tick();
      iv[1] = 1'b0; ir[1] = 1'b1; fl[1] = 1'b1;
      tick();
      fl[1] = 1'b0;
      tick();
      rs[1] = 1'b1;
      tick();
      rs[1] = 1'b0;
      chk("b_cnt_after_reset", 192'(cnt_b), 192'(4'd0));
      tick();

      // SKID=0: replace-on-issue, then combinational back-pressure
      iv[2] = 1'b1; ic[2] = 20'h00011; id[2] = {159'd0, 16'h1111};
      tick();
      ic[2] = 20'h00022; id[2] = {159'd0, 16'h2222};
      tick();
      ic[2] = 20'h00033; id[2] = {159'd0, 16'h3333}; ir[2] = 1'b0;
      tick();
      ir[2] = 1'b1;
      tick();
      iv[2] = 1'b0;
      tick(); tick();

      // Random traffic with occasional flushes on all instances
      repeat (300) begin
         for (int d = 0; d < 3; d++) begin
            iv[d] = ($urandom_range(0, 1) != 0);
            ir[d] = ($urandom_range(0, 3) != 0);
            fl[d] = ($urandom_range(0, 15) == 0);
            ic[d] = 20'($urandom) & cmask[d];
            id[d] = 175'({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom}) & dmask[d];
         end
         tick();
      end
      idle_all();
      tick(); tick(); tick();

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
